// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module exe_mem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int SIZE_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [SIZE_W-1:0] size_in,
    input  logic              li_in,
    input  logic              rf_en_in,
    input  logic [3:0]        flags_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_mem_in,
    output logic [DATA_W-1:0] address_data_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [SIZE_W-1:0] size_out,
    output logic              load_inst,
    output logic              rf_en,
    output logic [3:0]        flags_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PL_W = 2*DATA_W + RD_W + SIZE_W + 2 + 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [PL_W-1:0] in_pl;
    logic [PL_W-1:0] m_pl;
    logic [PL_W-1:0] s_pl;
    logic            m_vld;
    logic            s_vld;
    logic            m_vld_nxt;
    logic            s_vld_nxt;
    logic            m_load;
    logic            m_from_s;
    logic            s_load;
    logic            accept;
    logic            pop;
    logic            m_li;
    logic            m_rf;

    assign in_pl  = {data_in, alu_out, rd_in, size_in, li_in, rf_en_in, flags_in};
    assign accept = in_valid && in_ready;
    assign pop    = m_vld && out_ready;

    // Main/skid occupancy control; flush squashes everything held
    always_comb begin
        m_vld_nxt = m_vld;
        s_vld_nxt = s_vld;
        m_load    = 1'b0;
        m_from_s  = 1'b0;
        s_load    = 1'b0;
        if (flush) begin
            m_vld_nxt = 1'b0;
            s_vld_nxt = 1'b0;
        end else if (!m_vld || pop) begin
            if (s_vld) begin
                m_load    = 1'b1;
                m_from_s  = 1'b1;
                m_vld_nxt = 1'b1;
                s_vld_nxt = 1'b0;
            end else begin
                m_load    = accept;
                m_vld_nxt = accept;
            end
        end else if (accept) begin
            s_load    = 1'b1;
            s_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            m_vld <= m_vld_nxt;
            s_vld <= s_vld_nxt;
        end
    end

    // Payload only moves on a write so bubbles leave the outputs quiet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pl <= '0;
            s_pl <= '0;
        end else begin
            if (m_load) m_pl <= m_from_s ? s_pl : in_pl;
            if (s_load) s_pl <= in_pl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!flush && m_vld && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign in_ready  = !s_vld;
    assign out_valid = m_vld;
    assign {data_mem_in, address_data_out, rd_out, size_out, m_li, m_rf, flags_out} = m_pl;
    assign load_inst = m_li && m_vld;
    assign rf_en     = m_rf && m_vld;

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Directed bench for exe_mem_pipe_stage with a queue scoreboard of accepted entries.
module tb_exe_mem_pipe_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;
    localparam int SIZE_W = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] alu_out;
    logic [RD_W-1:0]   rd_in;
    logic [SIZE_W-1:0] size_in;
    logic              li_in;
    logic              rf_en_in;
    logic [3:0]        flags_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_mem_in;
    logic [DATA_W-1:0] address_data_out;
    logic [RD_W-1:0]   rd_out;
    logic [SIZE_W-1:0] size_out;
    logic              load_inst;
    logic              rf_en;
    logic [3:0]        flags_out;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] addr;
        logic [RD_W-1:0]   rd;
        logic [SIZE_W-1:0] size;
        logic              li;
        logic              rf;
        logic [3:0]        flags;
    } item_t;

    item_t q[$];
    item_t e;
    int    n_assert = 0;
    int    n_fail   = 0;

    exe_mem_pipe_stage #(
        .DATA_W(DATA_W), .RD_W(RD_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .alu_out(alu_out), .rd_in(rd_in), .size_in(size_in),
        .li_in(li_in), .rf_en_in(rf_en_in), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_mem_in(data_mem_in), .address_data_out(address_data_out),
        .rd_out(rd_out), .size_out(size_out), .load_inst(load_inst),
        .rf_en(rf_en), .flags_out(flags_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DATA_W-1:0] addr, input logic [RD_W-1:0] rd,
                         input logic li, input logic rf);
        in_valid = 1'b1;
        alu_out  = addr;
        data_in  = ~addr;
        rd_in    = rd;
        size_in  = rd[1:0];
        flags_in = rd ^ 4'h5;
        li_in    = li;
        rf_en_in = rf;
    endtask

    // Scoreboard at the falling edge, then advance past the next rising edge
    task automatic cycle();
        item_t it;
        @(negedge clk);
        if (reset_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 64'(q.size() > 0), 64'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("sb_addr", 64'(address_data_out), 64'(e.addr));
                        check("sb_data", 64'(data_mem_in), 64'(e.data));
                        check("sb_rd", 64'(rd_out), 64'(e.rd));
                        check("sb_size", 64'(size_out), 64'(e.size));
                        check("sb_flags", 64'(flags_out), 64'(e.flags));
                        check("sb_li", 64'(load_inst), 64'(e.li));
                        check("sb_rf", 64'(rf_en), 64'(e.rf));
                    end
                end
                if (in_valid && in_ready) begin
                    it.data  = data_in;
                    it.addr  = alu_out;
                    it.rd    = rd_in;
                    it.size  = size_in;
                    it.li    = li_in;
                    it.rf    = rf_en_in;
                    it.flags = flags_in;
                    q.push_back(it);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in = '0; alu_out = '0; rd_in = '0; size_in = '0;
        li_in = 1'b0; rf_en_in = 1'b0; flags_in = '0;
        cycle();
        cycle();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_addr", 64'(address_data_out), 64'd0);
        reset_n = 1'b1;
        cycle();

        // Streaming
        out_ready = 1'b1;
        drive(32'h10, 4'd1, 1'b0, 1'b1); cycle();
        check("str_valid0", 64'(out_valid), 64'd1);
        check("str_addr0", 64'(address_data_out), 64'h10);
        check("str_ready0", 64'(in_ready), 64'd1);
        drive(32'h14, 4'd2, 1'b0, 1'b1); cycle();
        check("str_addr1", 64'(address_data_out), 64'h14);
        check("str_rd1", 64'(rd_out), 64'd2);
        drive(32'h18, 4'd3, 1'b0, 1'b1); cycle();
        check("str_addr2", 64'(address_data_out), 64'h18);
        check("str_ready2", 64'(in_ready), 64'd1);
        in_valid = 1'b0; cycle();
        check("str_drain_valid", 64'(out_valid), 64'd0);
        check("str_drain_hold", 64'(address_data_out), 64'h18);

        // Control qualification
        drive(32'h20, 4'd4, 1'b1, 1'b1); cycle();
        check("ctl_li_on", 64'(load_inst), 64'd1);
        check("ctl_rf_on", 64'(rf_en), 64'd1);
        in_valid = 1'b0; cycle();
        check("ctl_li_off", 64'(load_inst), 64'd0);
        check("ctl_rf_off", 64'(rf_en), 64'd0);
        check("ctl_addr_hold", 64'(address_data_out), 64'h20);
        check("ctl_cnt", 64'(stall_cnt), 64'd0);

        // Stall and skid
        out_ready = 1'b0;
        drive(32'hA0, 4'd5, 1'b0, 1'b1); cycle();
        check("sk_valid", 64'(out_valid), 64'd1);
        check("sk_ready_a", 64'(in_ready), 64'd1);
        drive(32'hB0, 4'd6, 1'b1, 1'b0); cycle();
        check("sk_ready_b", 64'(in_ready), 64'd0);
        check("sk_addr_a", 64'(address_data_out), 64'hA0);
        drive(32'hC0, 4'd7, 1'b0, 1'b1); cycle();
        check("sk_held_ready", 64'(in_ready), 64'd0);
        check("sk_held_addr", 64'(address_data_out), 64'hA0);
        check("sk_cnt", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1; cycle();
        check("sk_rel_b", 64'(address_data_out), 64'hB0);
        check("sk_rel_ready", 64'(in_ready), 64'd1);
        cycle();
        check("sk_rel_c", 64'(address_data_out), 64'hC0);
        in_valid = 1'b0; cycle();
        check("sk_empty", 64'(out_valid), 64'd0);
        check("sk_q_empty", 64'(q.size()), 64'd0);
        check("sk_cnt_hold", 64'(stall_cnt), 64'd2);

        // Flush with a full skid
        out_ready = 1'b0;
        drive(32'h100, 4'd8, 1'b1, 1'b1); cycle();
        drive(32'h104, 4'd9, 1'b1, 1'b1); cycle();
        check("fl_full", 64'(in_ready), 64'd0);
        drive(32'h108, 4'd10, 1'b1, 1'b1); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_rf", 64'(rf_en), 64'd0);
        check("fl_li", 64'(load_inst), 64'd0);
        check("fl_cnt", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1; cycle();
        check("fl_no_c", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(32'h40, 4'd1, 1'b1, 1'b1); cycle();
        drive(32'h44, 4'd2, 1'b1, 1'b1); cycle();
        drive(32'h48, 4'd3, 1'b1, 1'b1); cycle();
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_li", 64'(load_inst), 64'd0);
        check("ar_rf", 64'(rf_en), 64'd0);
        check("ar_cnt", 64'(stall_cnt), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        q.delete();
        cycle();
        reset_n = 1'b1;
        cycle();

        // Counter saturation
        drive(32'h200, 4'd11, 1'b0, 1'b1); cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) cycle();
        check("sat_14", 64'(stall_cnt), 64'd14);
        for (int i = 0; i < 6; i++) cycle();
        check("sat_15", 64'(stall_cnt), 64'd15);
        check("sat_valid", 64'(out_valid), 64'd1);
        flush = 1'b1; cycle();
        flush = 1'b0;
        check("sat_flush_cnt", 64'(stall_cnt), 64'd15);
        check("sat_flush_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_stage.md
Name: exe_mem_pipe_stage

Overview:
Parametrised EXE→MEM pipeline stage for the processor datapath. It sits between the ALU/flag logic and the data-memory interface. It carries the EXE results (store data, ALU address, destination register, access size, load/RF-write controls, NZCV flags) across a valid/ready handshake with a 2-entry skid buffer, so MEM can stall without losing an in-flight instruction. It supports a synchronous flush for branch/exception squash and keeps a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 32, width of store data and ALU result/address
RD_W, 4, destination register index width
SIZE_W, 2, data-access size code width
CNT_W, 8, stall counter width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  EXE presents a valid instruction
in_ready  output  1  stage can accept; registered
data_in  input  DATA_W  store data from register file
alu_out  input  DATA_W  ALU result / memory address
rd_in  input  RD_W  destination register
size_in  input  SIZE_W  access size code
li_in  input  1  load instruction
rf_en_in  input  1  register-file write enable
flags_in  input  4  N,Z,C,V (bit3=N … bit0=V)
out_valid  output  1  MEM-side entry valid
out_ready  input  1  MEM consumes entry this cycle
data_mem_in  output  DATA_W  store data to memory
address_data_out  output  DATA_W  address / ALU result
rd_out  output  RD_W  destination register
size_out  output  SIZE_W  access size
load_inst  output  1  load control, qualified by out_valid
rf_en  output  1  RF write control, qualified by out_valid
flags_out  output  4  captured NZCV
stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry (M) drives outputs; skid entry (S) holds overflow. Each entry has a valid bit plus all payload fields.
- Reset (async, reset_n=0): M.valid=S.valid=0, all payload 0, stall_cnt=0. in_ready=1 and out_valid=0 immediately.
- in_ready = !S.valid (flop-derived, no combinational path from out_ready). out_valid = M.valid.
- Accept = in_valid && in_ready. Pop = M.valid && out_ready.
- Next-state per cycle, flush=0:
  - M empty or Pop, S empty: M ← input if Accept, else M.valid←0.
  - M empty or Pop, S full: M ← S, S.valid←0. Accept is impossible since in_ready=0.
  - M full and no Pop: if Accept, S ← input; M holds.
- Latency: 1 cycle from Accept to out_valid when empty. Throughput is 1/cycle when out_ready=1. Order is strictly FIFO.
- load_inst = M.li && M.valid. rf_en = M.rf_en && M.valid. Other outputs show M payload regardless of valid and hold their last value when invalid.
- Flush=1: next cycle M.valid=S.valid=0 and stall_cnt unchanged. Any Accept or Pop in the flush cycle is discarded; the pop's data is still visible that cycle. Flush overrides all simultaneous events.
- stall_cnt increments when out_valid && !out_ready and saturates at 2^CNT_W−1. It is cleared only by reset.
- Payload registers load only on write, to avoid toggling on bubbles.
- Flags are carried unmodified, with no flag evaluation in this block.

Test Plan:
- Reset mid-stream: drive 3 instructions, assert reset_n=0 asynchronously between edges → out_valid, load_inst, rf_en, stall_cnt go 0 at once; in_ready=1.
- Streaming: out_ready=1, back-to-back alu_out=0x10,0x14,0x18 with rd=1,2,3 → appear on address_data_out on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Stall/skid: out_ready=0, push A(0xA0), B(0xB0) → out_valid=1 with A; in_ready=0 after B; C held off. Release out_ready → A, B, C delivered in order, no loss or duplicate.
- Flush with full skid: M=A, S=B, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, rf_en=0, load_inst=0, C not captured.
- Control qualification: accept li_in=1, rf_en_in=1, then a bubble → load_inst/rf_en drop to 0 while address_data_out holds the last value.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15; then a flush leaves stall_cnt=15.
